// File: rtl/branch_resolve.sv
// Branch resolution stage: registers compare flags {ge, lt}, resolves conditional
// branches, and drives a one-cycle PC redirect plus a multi-cycle flush.
// Optional macro BRANCH_RESOLVE_FLAG_BYPASS_EN: same-cycle compare result feeds the branch.
module branch_resolve #(
  parameter int DATA_WIDTH   = 20,
  parameter int PC_WIDTH     = 20,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  cmp_wr,
  input  logic [DATA_WIDTH-1:0] cmp_result,
  input  logic                  br_valid,
  input  logic [1:0]            br_cond,
  input  logic [PC_WIDTH-1:0]   br_target,
  output logic                  pc_sel,
  output logic [PC_WIDTH-1:0]   pc_target,
  output logic                  flush,
  output logic [1:0]            flags_out,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t              state_p1, state_nx;
  logic [3:0]          cnt_p1, cnt_nx;
  logic [1:0]          flags_p1, flags_nx;
  logic                pc_sel_p1, pc_sel_nx;
  logic [PC_WIDTH-1:0] pc_target_p1, pc_target_nx;
  logic                flush_p1, flush_nx;
  logic [1:0]          eval_flags;
  logic                taken;

  // Only the two flag bits of the compare word carry meaning here.
  logic unused_cmp_bits;
  assign unused_cmp_bits = ^cmp_result[DATA_WIDTH-1:2];

  function automatic logic br_taken(input logic [1:0] cond, input logic [1:0] f);
    case (cond)
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = f[0];
      2'b10:   br_taken = f[1];
      default: br_taken = 1'b0;
    endcase
  endfunction

  always_comb begin
    eval_flags = flags_p1;
`ifdef BRANCH_RESOLVE_FLAG_BYPASS_EN
    if (cmp_wr) eval_flags = cmp_result[1:0];
`endif
    taken = br_valid && br_taken(br_cond, eval_flags);
  end

  always_comb begin
    state_nx     = state_p1;
    cnt_nx       = cnt_p1;
    flags_nx     = flags_p1;
    pc_sel_nx    = 1'b0;
    pc_target_nx = pc_target_p1;
    flush_nx     = flush_p1;
    case (state_p1)
      IDLE: begin
        if (!stall) begin
          if (cmp_wr) flags_nx = cmp_result[1:0];
          if (taken) begin
            state_nx     = FLUSH;
            cnt_nx       = CNT_INIT;
            pc_sel_nx    = 1'b1;
            pc_target_nx = br_target;
            flush_nx     = 1'b1;
          end
        end
      end
      FLUSH: begin
        // Wrong-path compares and branches are dropped while flushing.
        flush_nx = 1'b1;
        if (!stall) begin
          if (cnt_p1 == 4'd0) begin
            state_nx = IDLE;
            flush_nx = 1'b0;
          end else begin
            cnt_nx = cnt_p1 - 4'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        flush_nx = 1'b0;
      end
    endcase
  end

  // Stage p1: all state and outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1     <= IDLE;
      cnt_p1       <= 4'd0;
      flags_p1     <= 2'b00;
      pc_sel_p1    <= 1'b0;
      pc_target_p1 <= '0;
      flush_p1     <= 1'b0;
    end else begin
      state_p1     <= state_nx;
      cnt_p1       <= cnt_nx;
      flags_p1     <= flags_nx;
      pc_sel_p1    <= pc_sel_nx;
      pc_target_p1 <= pc_target_nx;
      flush_p1     <= flush_nx;
    end
  end

  assign pc_sel    = pc_sel_p1;
  assign pc_target = pc_target_p1;
  assign flush     = flush_p1;
  assign flags_out = flags_p1;
  assign busy      = (state_p1 == FLUSH);

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: a cycle model pushes expected outputs per
// driven cycle; each scenario task pops and compares them against observed outputs.
module tb_branch_resolve;

  localparam int DW = 20;
  localparam int PW = 20;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          cmp_wr;
  logic [DW-1:0] cmp_result;
  logic          br_valid;
  logic [1:0]    br_cond;
  logic [PW-1:0] br_target;
  logic          pc_sel;
  logic [PW-1:0] pc_target;
  logic          flush;
  logic [1:0]    flags_out;
  logic          busy;

  always #5 clk = ~clk;

  branch_resolve #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .cmp_wr(cmp_wr), .cmp_result(cmp_result),
    .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target), .pc_sel(pc_sel),
    .pc_target(pc_target), .flush(flush), .flags_out(flags_out), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];

  // Reference model state
  logic          m_busy;
  int            m_cnt;
  logic [1:0]    m_flags;
  logic          m_pcsel;
  logic [PW-1:0] m_pct;

  task automatic model_reset();
    m_busy = 0; m_cnt = 0; m_flags = 2'b00; m_pcsel = 0; m_pct = '0;
  endtask

  task automatic drive(input logic s, input logic cw, input logic [DW-1:0] cr,
                       input logic bv, input logic [1:0] bc, input logic [PW-1:0] bt);
    logic [1:0] f;
    logic tk;
    stall = s; cmp_wr = cw; cmp_result = cr; br_valid = bv; br_cond = bc; br_target = bt;
    f = m_flags;
`ifdef BRANCH_RESOLVE_FLAG_BYPASS_EN
    if (cw) f = cr[1:0];
`endif
    tk = bv && ((bc == 2'b00) || (bc == 2'b01 && f[0]) || (bc == 2'b10 && f[1]));
    if (!m_busy) begin
      if (!s) begin
        if (tk) begin
          m_pcsel = 1; m_pct = bt; m_busy = 1; m_cnt = FC - 1;
        end
        if (cw) m_flags = cr[1:0];
      end
    end else begin
      m_pcsel = 0;
      if (!s) begin
        if (m_cnt == 0) m_busy = 0;
        else m_cnt = m_cnt - 1;
      end
    end
    exp_q.push_back({m_pcsel, m_pct, m_busy, m_flags, m_busy});
    @(posedge clk); #1;
    obs_q.push_back({pc_sel, pc_target, flush, flags_out, busy});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, '0, 0, 2'b00, '0);
  endtask

  task automatic test_reset();
    logic [24:0] e, o;
    int i;
    rst_n = 0; stall = 0; cmp_wr = 0; cmp_result = '0; br_valid = 0; br_cond = 0; br_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    total++;
    if ({pc_sel, pc_target, flush, flags_out, busy} !== 25'd0) begin
      bad++; $display("FAIL reset_initial got=%h want=0", {pc_sel, pc_target, flush, flags_out, busy});
    end
    drive(0, 1, 20'h00003, 0, 2'b00, '0);
    drive(0, 0, '0, 1, 2'b00, 20'h12345);
    #2 rst_n = 0;
    #1;
    model_reset();
    total++;
    if ({pc_sel, pc_target, flush, flags_out, busy} !== 25'd0) begin
      bad++; $display("FAIL reset_async got=%h want=0", {pc_sel, pc_target, flush, flags_out, busy});
    end
    @(posedge clk); #2 rst_n = 1;
    total++;
    if (flags_out !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release flags=%b busy=%b want flags=00 busy=0", flags_out, busy);
    end
    idle(2);
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset step%0d got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_cmp_branch();
    logic [24:0] e, o;
    int i;
    drive(0, 1, 20'h00001, 0, 2'b00, '0);
    drive(0, 0, '0, 1, 2'b01, 20'h00ABC);
    total++;
    if (pc_sel !== 1'b1 || pc_target !== 20'h00ABC || flush !== 1'b1) begin
      bad++; $display("FAIL cmp_branch_redirect sel=%b tgt=%h flush=%b want 1 00abc 1", pc_sel, pc_target, flush);
    end
    idle(3);
    drive(0, 1, 20'hFFFFE, 0, 2'b00, '0);
    total++;
    if (flags_out !== 2'b10) begin
      bad++; $display("FAIL upper_bits_ignored got=%b want=10", flags_out);
    end
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL cmp_branch step%0d got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_not_taken();
    logic [24:0] e, o;
    int i;
    drive(0, 1, 20'h00002, 0, 2'b00, '0);
    drive(0, 0, '0, 1, 2'b01, 20'h00111);
    drive(0, 0, '0, 1, 2'b11, 20'h00222);
    total++;
    if (pc_sel !== 1'b0 || flush !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL not_taken sel=%b flush=%b busy=%b want 0 0 0", pc_sel, flush, busy);
    end
    drive(0, 0, '0, 1, 2'b00, 20'h00333);
    idle(3);
    drive(0, 1, 20'h00000, 0, 2'b00, '0);
    drive(0, 0, '0, 1, 2'b01, 20'h00444);
    drive(0, 0, '0, 1, 2'b10, 20'h00555);
    drive(0, 1, 20'h00003, 0, 2'b00, '0);
    drive(0, 0, '0, 1, 2'b10, 20'h00666);
    idle(3);
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL not_taken step%0d got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_simultaneous();
    logic [24:0] e, o;
    logic want_sel;
    int i;
`ifdef BRANCH_RESOLVE_FLAG_BYPASS_EN
    want_sel = 1'b1;
`else
    want_sel = 1'b0;
`endif
    drive(0, 1, 20'h00000, 0, 2'b00, '0);
    drive(0, 1, 20'h00002, 1, 2'b10, 20'h00777);
    total++;
    if (pc_sel !== want_sel) begin
      bad++; $display("FAIL simul_taken got=%b want=%b", pc_sel, want_sel);
    end
    total++;
    if (flags_out !== 2'b10) begin
      bad++; $display("FAIL simul_flags got=%b want=10", flags_out);
    end
    idle(3);
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL simultaneous step%0d got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_stall_flush();
    logic [24:0] e, o;
    int i, nflush, nsel;
    drive(1, 1, 20'h00001, 1, 2'b00, 20'h00999);
    total++;
    if (flags_out !== 2'b10 || pc_sel !== 1'b0) begin
      bad++; $display("FAIL stall_idle flags=%b sel=%b want 10 0", flags_out, pc_sel);
    end
    nflush = 0; nsel = 0;
    drive(0, 0, '0, 1, 2'b00, 20'h0AAAA);
    nflush += flush; nsel += pc_sel;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 20'h00001, 1, 2'b00, 20'h0BBBB);
      nflush += flush; nsel += pc_sel;
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0, (k == 0), 2'b00, 20'h0CCCC);
      nflush += flush; nsel += pc_sel;
    end
    total++;
    if (nflush != 5 || nsel != 1) begin
      bad++; $display("FAIL stall_flush_len flush=%0d sel=%0d want 5 1", nflush, nsel);
    end
    total++;
    if (pc_target !== 20'h0AAAA || flags_out !== 2'b10) begin
      bad++; $display("FAIL flush_ignores tgt=%h flags=%b want 0aaaa 10", pc_target, flags_out);
    end
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_flush step%0d got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_reset_midflush();
    logic [24:0] e, o;
    int i;
    drive(0, 0, '0, 1, 2'b00, 20'h0DDDD);
    #2 rst_n = 0;
    #1;
    total++;
    if (flush !== 1'b0 || busy !== 1'b0 || pc_sel !== 1'b0) begin
      bad++; $display("FAIL reset_midflush flush=%b busy=%b sel=%b want 0 0 0", flush, busy, pc_sel);
    end
    model_reset();
    @(posedge clk); #2 rst_n = 1;
    drive(0, 0, '0, 1, 2'b11, 20'h0EEEE);
    idle(2);
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_midflush step%0d got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] e, o;
    int i;
    for (int k = 0; k < 300; k++)
      drive(($urandom_range(0, 3) == 0), 1'($urandom), DW'($urandom), 1'($urandom),
            2'($urandom), PW'($urandom));
    idle(4);
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL back_to_back step%0d got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_cmp_branch();
    test_not_taken();
    test_simultaneous();
    test_stall_flush();
    test_reset_midflush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute/memory-boundary stage directly downstream of the compare unit.
- Captures the compare result word into a registered 2-bit flag set: bit0 = lt, bit1 = ge.
- Resolves conditional branches against those flags.
- On a taken branch, drives a one-cycle PC redirect and a multi-cycle pipeline flush through a small state machine.

Parameters:
- DATA_WIDTH, 20, width of the compare result word consumed from the compare stage.
- PC_WIDTH, 20, width of branch target / redirect address.
- FLUSH_CYCLES, 2, cycles flush is held after a taken branch (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  pipeline stall; freezes all state updates.
- cmp_wr  input  1  compare instruction valid this cycle; write flags.
- cmp_result  input  DATA_WIDTH  compare stage output; only bits [1:0] are used.
- br_valid  input  1  branch instruction valid this cycle.
- br_cond  input  2  00 = always, 01 = lt, 10 = ge, 11 = never.
- br_target  input  PC_WIDTH  branch target address.
- pc_sel  output  1  one-cycle redirect strobe to the fetch PC mux.
- pc_target  output  PC_WIDTH  redirect address, valid while pc_sel=1.
- flush  output  1  squash younger pipeline stages.
- flags_out  output  2  current registered flags {ge, lt}.
- busy  output  1  high while in FLUSH state.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following go to 0: flags, pc_sel, pc_target, flush, busy, flush counter. State = IDLE. Release is synchronous to clk.
- Flag write: in IDLE with stall=0 and cmp_wr=1, flags <= cmp_result[1:0] at the clock edge.
  - Upper cmp_result bits are ignored.
  - A disabled compare (all zeros) stores 00. Neither lt nor ge is then taken.
  - Flag patterns 11 and 00 are stored as-is. No error is raised.
- Branch evaluation: in IDLE with stall=0 and br_valid=1:
  - taken = (cond==00) | (cond==01 & lt) | (cond==10 & ge). cond==11 is never taken.
  - Flags used are the registered flags, not the same-cycle cmp_result (see the optional feature for the bypass).
- Simultaneous cmp_wr and br_valid: the branch uses the pre-write flags. The flag write still occurs.
- Taken branch at edge N:
  - After edge N: pc_sel=1 and pc_target=br_target for exactly one cycle; flush=1; busy=1.
  - State -> FLUSH, counter <= FLUSH_CYCLES-1.
- Not-taken branch: no output change; stays in IDLE.
- FLUSH state:
  - flush=1 and busy=1 throughout.
  - cmp_wr and br_valid are ignored (wrong-path instructions).
  - pc_sel returns to 0 after its single cycle, even if stall=1.
  - Counter decrements only when stall=0.
  - When counter==0 and stall=0 at an edge: state -> IDLE, flush=0, busy=0.
  - Flush therefore lasts FLUSH_CYCLES unstalled cycles in total.
- Stall in IDLE: flags and outputs hold. No evaluation and no flag write.
- Reset mid-FLUSH: immediate return to IDLE with all outputs 0. The pending redirect is lost.
- All outputs are registered. Latency from branch input to pc_sel/flush is 1 cycle.

Optional Feature:
- Macro: BRANCH_RESOLVE_FLAG_BYPASS_EN.
- Defined: when cmp_wr=1 and br_valid=1 in the same unstalled IDLE cycle, the branch evaluates against cmp_result[1:0] instead of the registered flags. The register write is unchanged.
- Undefined: branches always use the registered flags, as described in Behaviour.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; after release, flags_out=00 and busy=0.
- Compare then branch: cmp_wr with cmp_result=0x00001; next cycle br_valid, cond=01, target=0x00ABC -> pc_sel=1 for 1 cycle with pc_target=0x00ABC; flush=1 for 2 cycles; busy clears on cycle 3.
- Not taken: flags=10 (ge); branch cond=01 -> pc_sel=0, flush=0, state stays IDLE. Repeat with cond=11 and cond=00 -> not taken, then taken.
- Simultaneous write and branch: flags=00; same cycle cmp_wr (0x00002) and br cond=10.
  - Without the macro -> not taken, flags_out=10 next cycle.
  - With BRANCH_RESOLVE_FLAG_BYPASS_EN -> taken.
- Stall in FLUSH: taken branch, then stall=1 for 3 cycles -> flush held for 5 cycles total and pc_sel only 1 cycle. A br_valid (cond=00) presented during FLUSH -> ignored.
- Reset mid-FLUSH: rst_n=0 one cycle after a taken branch -> flush, busy and pc_sel drop immediately; state is IDLE after release.
